etapa_busqueda: RTL and testbench
=================================

# etapa_busqueda

Instruction-fetch stage with IF/ID pipeline register for the MIPS datapath. It holds the PC, drives the instruction-memory address and captures the returned word. It presents the instruction, its opcode field and PC+4 to the decode stage, where the opcode feeds the control unit. It also handles pipeline stall, taken-branch redirect/flush and a fetched-instruction counter.

## Interface
- ANCHO_PC, 32, PC/address width (≥ 3).
- PC_RESET, 0, PC value loaded on reset (bits [1:0] must be 00).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- Detener  in  1  stall request from hazard unit; hold PC and IF/ID.
- SaltoTomado  in  1  taken branch resolved downstream (Branch & Zero).
- DirSalto  in  ANCHO_PC  branch target; bits [1:0] ignored, forced to 00.
- InstrIn  in  32  instruction word from imem; combinational read of DirInstr.
- DirInstr  out  ANCHO_PC  imem address, equals the PC register.
- Instruccion_ID  out  32  registered instruction.
- OpCode_ID  out  6  Instruccion_ID[31:26].
- PCmas4_ID  out  ANCHO_PC  registered PC+4 of that instruction.
- Valido_ID  out  1  IF/ID holds a real instruction.
- Detenido  out  1  FSM is in DETENIDO.
- ContInstr  out  32  count of valid instructions loaded into IF/ID; saturating.

## Operation
- Reset (rst_n low, any time, including mid-stall):
  - PC=PC_RESET, Instruccion_ID=0 (NOP, opcode 000000), PCmas4_ID=0.
  - Valido_ID=0, Detenido=0, ContInstr=0, state INICIO.
- FSM states:
  - INICIO: one cycle after reset release. PC held, IF/ID stays bubble. Always goes to CORRIENDO, regardless of inputs.
  - CORRIENDO / DETENIDO: identical update rules, listed below by priority. Only Detenido differs.
- Update rules, highest priority first:
  1. SaltoTomado=1: PC<=DirSalto&~3. IF/ID flushed: Instruccion_ID=0, Valido_ID=0, PCmas4_ID=0. Next state CORRIENDO. Wins over Detener, because the branch is older than the stalled decode instruction.
  2. Detener=1: PC, IF/ID and ContInstr hold. Next state DETENIDO.
  3. Otherwise: PC<=PC+4; Instruccion_ID<=InstrIn; PCmas4_ID<=PC+4; Valido_ID<=1; ContInstr+=1. Next state CORRIENDO.
- Arithmetic:
  - PC+4 is modulo 2^ANCHO_PC; 0x...FFFC wraps to 0.
  - ContInstr saturates at 0xFFFFFFFF.
- OpCode_ID is purely a slice of Instruccion_ID, with no extra register.

## Timing
- All state updates happen on the rising clk edge. Reset acts immediately, asynchronously; release takes effect at the next edge.
- DirInstr changes only after an edge. InstrIn is sampled at the next edge.
- Fetch latency: the word at address A appears on Instruccion_ID one cycle after DirInstr=A.
- Redirect: the cycle after SaltoTomado, DirInstr=target and Valido_ID=0. The target instruction is valid one cycle later. Branch penalty: exactly one bubble created by this block.
- Stall: outputs are bit-identical for every cycle Detener is high. Resume on the first edge with Detener=0.
- Detenido is registered: it rises the cycle after the first stalled edge and falls the cycle after release.

## Test plan
- Reset then run, with imem returning word = address: at 0, 4 and 8, PC_RESET=0 gives DirInstr 0, 0 (INICIO), 4, 8. Instruccion_ID is 0, 0, 0x0, 0x4 with Valido_ID 0, 0, 1, 1. ContInstr reaches 2.
- Stall: Detener high 3 cycles while PC=0x10 → DirInstr stays 0x10 and Instruccion_ID holds its value. Detenido is 1 for 3 cycles; ContInstr is unchanged. Afterwards fetch resumes at 0x10 → 0x14.
- Branch: SaltoTomado=1 with DirSalto=0x41 (misaligned) at PC=0x20 → next DirInstr=0x40 with Valido_ID=0, Instruccion_ID=0. Next cycle, Instruccion_ID equals the word at 0x40.
- Simultaneous: SaltoTomado=1 and Detener=1 in DETENIDO → redirect to DirSalto, flush, Detenido falls.
- Wrap: PC_RESET=0xFFFFFFF8 → DirInstr goes 0xFFFFFFF8, 0xFFFFFFFC, 0x0. PCmas4_ID=0x0 for the instruction at 0xFFFFFFFC.
- Reset mid-operation: rst_n low asynchronously during a stall → all outputs immediately go to their reset values. INICIO repeats after release.

Source files
------------

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: PC register, imem address and IF/ID pipeline register.
// Handles stall, taken-branch redirect with flush, and a saturating fetch counter.
module etapa_busqueda #(
  parameter int                     ANCHO_PC = 32,
  parameter logic [ANCHO_PC-1:0]    PC_RESET = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Detener,
  input  logic                SaltoTomado,
  input  logic [ANCHO_PC-1:0] DirSalto,
  input  logic [31:0]         InstrIn,
  output logic [ANCHO_PC-1:0] DirInstr,
  output logic [31:0]         Instruccion_ID,
  output logic [5:0]          OpCode_ID,
  output logic [ANCHO_PC-1:0] PCmas4_ID,
  output logic                Valido_ID,
  output logic                Detenido,
  output logic [31:0]         ContInstr
);

  typedef enum logic [1:0] {
    INICIO,
    CORRIENDO,
    DETENIDO
  } estado_t;

  localparam logic [ANCHO_PC-1:0] MASCARA = ~ANCHO_PC'(3);
  localparam logic [ANCHO_PC-1:0] CUATRO  = ANCHO_PC'(4);

  estado_t             estado_q, estado_d;
  logic [ANCHO_PC-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [ANCHO_PC-1:0] pcmas4_q, pcmas4_d;
  logic                valido_q, valido_d;
  logic [31:0]         cont_q, cont_d;
  logic [ANCHO_PC-1:0] pc_sig;

  assign pc_sig = pc_q + CUATRO;

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcmas4_d = pcmas4_q;
    valido_d = valido_q;
    cont_d   = cont_q;
    unique case (estado_q)
      INICIO: begin
        estado_d = CORRIENDO;
      end
      CORRIENDO, DETENIDO: begin
        // The branch is older than the stalled decode word, so it wins.
        if (SaltoTomado) begin
          pc_d     = DirSalto & MASCARA;
          instr_d  = '0;
          pcmas4_d = '0;
          valido_d = 1'b0;
          estado_d = CORRIENDO;
        end else if (Detener) begin
          estado_d = DETENIDO;
        end else begin
          pc_d     = pc_sig;
          instr_d  = InstrIn;
          pcmas4_d = pc_sig;
          valido_d = 1'b1;
          cont_d   = (cont_q == '1) ? cont_q : cont_q + 32'd1;
          estado_d = CORRIENDO;
        end
      end
      default: begin
        estado_d = INICIO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= INICIO;
      pc_q     <= PC_RESET;
      instr_q  <= '0;
      pcmas4_q <= '0;
      valido_q <= 1'b0;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcmas4_q <= pcmas4_d;
      valido_q <= valido_d;
      cont_q   <= cont_d;
    end
  end

  assign DirInstr       = pc_q;
  assign Instruccion_ID = instr_q;
  assign OpCode_ID      = instr_q[31:26];
  assign PCmas4_ID      = pcmas4_q;
  assign Valido_ID      = valido_q;
  assign Detenido       = (estado_q == DETENIDO);
  assign ContInstr      = cont_q;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Bench for etapa_busqueda: directed literal checks plus randomized run
// compared every cycle against a behavioural fetch-stage model.
module tb_etapa_busqueda;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Detener;
  logic        SaltoTomado;
  logic [31:0] DirSalto;
  logic        modo;

  logic [31:0] in0, dir0, ins0, p40, cnt0;
  logic [5:0]  op0;
  logic        val0, det0;
  logic [31:0] in1, dir1, ins1, p41, cnt1;
  logic [5:0]  op1;
  logic        val1, det1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(logic [31:0] a, logic m);
    return m ? ((a * 32'h9E3779B1) ^ 32'hC3A50F1E) : a;
  endfunction

  assign in0 = imem(dir0, modo);
  assign in1 = imem(dir1, modo);

  etapa_busqueda #(.ANCHO_PC(32), .PC_RESET(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .Detener(Detener),
    .SaltoTomado(SaltoTomado), .DirSalto(DirSalto), .InstrIn(in0),
    .DirInstr(dir0), .Instruccion_ID(ins0), .OpCode_ID(op0),
    .PCmas4_ID(p40), .Valido_ID(val0), .Detenido(det0),
    .ContInstr(cnt0)
  );

  etapa_busqueda #(.ANCHO_PC(32), .PC_RESET(32'hFFFFFFF8)) dut1 (
    .clk(clk), .rst_n(rst_n), .Detener(Detener),
    .SaltoTomado(SaltoTomado), .DirSalto(DirSalto), .InstrIn(in1),
    .DirInstr(dir1), .Instruccion_ID(ins1), .OpCode_ID(op1),
    .PCmas4_ID(p41), .Valido_ID(val1), .Detenido(det1),
    .ContInstr(cnt1)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
    bit          valid;
    bit          stalled;
    bit          started;
  } mst_t;

  function automatic mst_t m_reset(logic [31:0] pcr);
    mst_t s;
    s.pc = pcr; s.instr = 0; s.pc4 = 0; s.cnt = 0;
    s.valid = 0; s.stalled = 0; s.started = 0;
    return s;
  endfunction

  function automatic mst_t step(mst_t s, bit det, bit br,
                                logic [31:0] tgt, logic [31:0] word);
    mst_t n = s;
    if (!s.started) begin
      n.started = 1;
    end else if (br) begin
      n.pc = tgt & ~32'd3;
      n.instr = 0; n.pc4 = 0; n.valid = 0; n.stalled = 0;
    end else if (det) begin
      n.stalled = 1;
    end else begin
      n.pc = s.pc + 32'd4;
      n.instr = word;
      n.pc4 = s.pc + 32'd4;
      n.valid = 1;
      n.stalled = 0;
      if (s.cnt != 32'hFFFFFFFF) n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  mst_t m0, m1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= m_reset(32'h0);
      m1 <= m_reset(32'hFFFFFFF8);
    end else begin
      m0 <= step(m0, Detener, SaltoTomado, DirSalto, imem(m0.pc, modo));
      m1 <= step(m1, Detener, SaltoTomado, DirSalto, imem(m1.pc, modo));
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m0.DirInstr", dir0, m0.pc);
    chk("m0.Instr", ins0, m0.instr);
    chk("m0.OpCode", {26'd0, op0}, {26'd0, m0.instr[31:26]});
    chk("m0.PCmas4", p40, m0.pc4);
    chk("m0.Valido", {31'd0, val0}, {31'd0, m0.valid});
    chk("m0.Detenido", {31'd0, det0}, {31'd0, m0.stalled});
    chk("m0.Cont", cnt0, m0.cnt);
    chk("m1.DirInstr", dir1, m1.pc);
    chk("m1.Instr", ins1, m1.instr);
    chk("m1.PCmas4", p41, m1.pc4);
    chk("m1.Valido", {31'd0, val1}, {31'd0, m1.valid});
    chk("m1.Detenido", {31'd0, det1}, {31'd0, m1.stalled});
    chk("m1.Cont", cnt1, m1.cnt);
  end

  task automatic chk_reset();
    chk("rst.DirInstr", dir0, 32'h0);
    chk("rst.Instr", ins0, 32'h0);
    chk("rst.OpCode", {26'd0, op0}, 32'h0);
    chk("rst.PCmas4", p40, 32'h0);
    chk("rst.Valido", {31'd0, val0}, 32'h0);
    chk("rst.Detenido", {31'd0, det0}, 32'h0);
    chk("rst.Cont", cnt0, 32'h0);
    chk("rst.DirInstr1", dir1, 32'hFFFFFFF8);
  endtask

  initial begin
    rst_n = 1'b0;
    Detener = 1'b0;
    SaltoTomado = 1'b0;
    DirSalto = 32'h0;
    modo = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ini.DirInstr", dir0, 32'h0);
    chk("ini.Valido", {31'd0, val0}, 32'h0);
    chk("ini.DirInstr1", dir1, 32'hFFFFFFF8);
    @(negedge clk);
    chk("run.DirInstr4", dir0, 32'h4);
    chk("run.Instr0", ins0, 32'h0);
    chk("run.Valido", {31'd0, val0}, 32'h1);
    chk("wrap.DirFC", dir1, 32'hFFFFFFFC);
    chk("wrap.PC4_FC", p41, 32'hFFFFFFFC);
    @(negedge clk);
    chk("run.DirInstr8", dir0, 32'h8);
    chk("run.Instr4", ins0, 32'h4);
    chk("run.Cont2", cnt0, 32'd2);
    chk("wrap.Dir0", dir1, 32'h0);
    chk("wrap.PC4_0", p41, 32'h0);
    repeat (2) @(negedge clk);
    chk("pre.DirInstr10", dir0, 32'h10);
    Detener = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.DirInstr", dir0, 32'h10);
      chk("stall.Instr", ins0, 32'hC);
      chk("stall.Detenido", {31'd0, det0}, 32'h1);
      chk("stall.Cont", cnt0, 32'd4);
    end
    Detener = 1'b0;
    @(negedge clk);
    chk("resume.DirInstr", dir0, 32'h14);
    chk("resume.Instr", ins0, 32'h10);
    chk("resume.Detenido", {31'd0, det0}, 32'h0);
    chk("resume.Cont", cnt0, 32'd5);
    repeat (3) @(negedge clk);
    chk("pre.DirInstr20", dir0, 32'h20);
    SaltoTomado = 1'b1;
    DirSalto = 32'h41;
    @(negedge clk);
    SaltoTomado = 1'b0;
    chk("br.DirInstr", dir0, 32'h40);
    chk("br.Valido", {31'd0, val0}, 32'h0);
    chk("br.Instr", ins0, 32'h0);
    chk("br.Cont", cnt0, 32'd8);
    @(negedge clk);
    chk("br.Target", ins0, 32'h40);
    chk("br.TargetPC4", p40, 32'h44);
    chk("br.TargetValid", {31'd0, val0}, 32'h1);
    Detener = 1'b1;
    @(negedge clk);
    chk("sim.Detenido", {31'd0, det0}, 32'h1);
    SaltoTomado = 1'b1;
    DirSalto = 32'h100;
    @(negedge clk);
    SaltoTomado = 1'b0;
    chk("sim.DirInstr", dir0, 32'h100);
    chk("sim.Valido", {31'd0, val0}, 32'h0);
    chk("sim.Detenido", {31'd0, det0}, 32'h0);
    @(negedge clk);
    chk("mid.Detenido", {31'd0, det0}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    Detener = 1'b0;
    @(negedge clk);
    chk("reini.DirInstr", dir0, 32'h0);
    chk("reini.Valido", {31'd0, val0}, 32'h0);
    @(negedge clk);
    chk("reini.DirInstr4", dir0, 32'h4);
    modo = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      Detener = ($urandom_range(0, 99) < 30);
      SaltoTomado = ($urandom_range(0, 99) < 10);
      DirSalto = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
